// File: rtl/n101_gnrl_wishb8toicb32_if.sv
// Bus bundle for the 8-bit Wishbone to 32-bit ICB bridge.
// The slave view belongs to the bridge. The master view belongs to the WB initiator and the ICB target together.
interface n101_gnrl_wishb8toicb32_if #(
    parameter int AW = 32
) ();
    logic [AW-1:0] wb_adr;
    logic [7:0]    wb_dat_w;
    logic [7:0]    wb_dat_r;
    logic          wb_we;
    logic          wb_stb;
    logic          wb_cyc;
    logic          wb_ack;
    logic          wb_err;
    logic          o_icb_cmd_valid;
    logic          o_icb_cmd_ready;
    logic          o_icb_cmd_read;
    logic [AW-1:0] o_icb_cmd_addr;
    logic [31:0]   o_icb_cmd_wdata;
    logic [3:0]    o_icb_cmd_wmask;
    logic [1:0]    o_icb_cmd_size;
    logic          o_icb_rsp_valid;
    logic          o_icb_rsp_ready;
    logic          o_icb_rsp_err;
    logic [31:0]   o_icb_rsp_rdata;

    modport slave (
        input  wb_adr, wb_dat_w, wb_we, wb_stb, wb_cyc,
        input  o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_err, o_icb_rsp_rdata,
        output wb_dat_r, wb_ack, wb_err,
        output o_icb_cmd_valid, o_icb_cmd_read, o_icb_cmd_addr, o_icb_cmd_wdata,
        output o_icb_cmd_wmask, o_icb_cmd_size, o_icb_rsp_ready
    );

    modport master (
        output wb_adr, wb_dat_w, wb_we, wb_stb, wb_cyc,
        output o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_err, o_icb_rsp_rdata,
        input  wb_dat_r, wb_ack, wb_err,
        input  o_icb_cmd_valid, o_icb_cmd_read, o_icb_cmd_addr, o_icb_cmd_wdata,
        input  o_icb_cmd_wmask, o_icb_cmd_size, o_icb_rsp_ready
    );
endinterface

// File: rtl/n101_gnrl_wishb8toicb32.sv
// Bridges one 8-bit Wishbone classic byte access at a time onto a single 32-bit ICB transaction.
// All ICB outputs come from registers or state only, so there is no combinational path from WB to ICB.
module n101_gnrl_wishb8toicb32 #(
    parameter int AW = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    n101_gnrl_wishb8toicb32_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] adr;
    logic [7:0]    wbyte;
    logic          rd;
    logic [1:0]    lane;
    logic [3:0]    wmask;
    logic [7:0]    rbyte;
    logic          err;
    logic          abort;
    logic          latch_req;
    logic          capture;
    logic          cmd_vld;
    logic          rsp_rdy;

    always_comb begin
        state_nxt = state;
        latch_req = 1'b0;
        capture   = 1'b0;
        cmd_vld   = 1'b0;
        rsp_rdy   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wb_cyc && bus.wb_stb) begin
                    latch_req = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                cmd_vld = 1'b1;
                rsp_rdy = 1'b1;
                if (bus.o_icb_cmd_ready) begin
                    // A response arriving in the handshake cycle counts as accepted.
                    if (bus.o_icb_rsp_valid) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RSP;
                    end
                end
            end
            RSP: begin
                rsp_rdy = 1'b1;
                if (bus.o_icb_rsp_valid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            adr   <= '0;
            wbyte <= '0;
            rd    <= 1'b0;
            lane  <= 2'b00;
            wmask <= 4'b0000;
            rbyte <= 8'h00;
            err   <= 1'b0;
            abort <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_req) begin
                adr   <= bus.wb_adr;
                wbyte <= bus.wb_dat_w;
                rd    <= ~bus.wb_we;
                lane  <= bus.wb_adr[1:0];
                wmask <= bus.wb_we ? (4'b0001 << bus.wb_adr[1:0]) : 4'b0000;
                abort <= 1'b0;
            end
            // Once the initiator walks away, the in-flight ICB transaction still finishes but stays silent on WB.
            if ((state == CMD || state == RSP) && !bus.wb_cyc) begin
                abort <= 1'b1;
            end
            if (capture) begin
                rbyte <= bus.o_icb_rsp_rdata[{lane, 3'b000} +: 8];
                err   <= bus.o_icb_rsp_err;
            end
        end
    end

    assign bus.o_icb_cmd_valid = cmd_vld;
    assign bus.o_icb_rsp_ready = rsp_rdy;
    assign bus.o_icb_cmd_read  = rd;
    assign bus.o_icb_cmd_addr  = adr;
    assign bus.o_icb_cmd_wdata = {4{wbyte}};
    assign bus.o_icb_cmd_wmask = wmask;
    assign bus.o_icb_cmd_size  = 2'b00;

    assign bus.wb_ack   = (state == DONE) && bus.wb_cyc && bus.wb_stb && !abort && !err;
    assign bus.wb_err   = (state == DONE) && bus.wb_cyc && bus.wb_stb && !abort && err;
    assign bus.wb_dat_r = (state == DONE && rd) ? rbyte : 8'h00;

endmodule
